pulse_inst_scheduler: RTL and testbench
=======================================

Name: pulse_inst_scheduler

Overview:
- Downstream consumer of the pulse mask decoder's instruction-list write port.
- Holds the instruction list: 2^INST_LIST_ADDR_WIDTH entries, each {start_time, direction}.
- Retires entries in write order. For each entry, plays a pulse of programmable length when the global counter reaches the entry's start_time.
- Drives the per-qubit pulse generator's direction/enable inputs.

Parameters:
- GLB_COUNTER_WIDTH, 24, width of global time counter and stored start_time
- INST_LIST_ADDR_WIDTH, 5, list address width; depth = 2^INST_LIST_ADDR_WIDTH
- DIRECTION_WIDTH, 2, pulse direction code width
- INST_LIST_DATA_WIDTH, 26, = GLB_COUNTER_WIDTH + DIRECTION_WIDTH; layout {start_time, direction}
- PULSE_LEN_WIDTH, 8, width of pulse duration field

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- inst_list_wr_en  in  1  write strobe from decoder
- inst_list_wr_addr  in  INST_LIST_ADDR_WIDTH  write slot
- inst_list_wr_data  in  INST_LIST_DATA_WIDTH  {start_time, direction}
- glb_counter  in  GLB_COUNTER_WIDTH  free-running global time
- pulse_len  in  PULSE_LEN_WIDTH  pulse duration in cycles, sampled at pulse start
- pulse_active  out  1  high while pulse plays
- pulse_direction  out  DIRECTION_WIDTH  direction of current/last pulse
- pulse_start  out  1  one-cycle strobe on first active cycle
- late_drop  out  1  one-cycle strobe when head entry is already in the past
- overflow  out  1  sticky: write hit an unconsumed slot
- list_empty  out  1  no valid entry at read pointer
- rd_addr  out  INST_LIST_ADDR_WIDTH  current read pointer

Behaviour:
- Storage and valid bits:
  - Register-file storage with one valid bit per slot.
  - A write sets the slot's valid bit and stores the data.
  - Retiring an entry clears its valid bit.
  - Write and clear on the same slot in the same cycle: the write wins (valid stays 1, new data stored).
- Overflow:
  - A write to a slot whose valid bit is already 1 (and not being cleared that cycle) overwrites the data and sets overflow.
  - overflow clears only on rst.
- Read pointer: rd_addr increments by 1 on each retire and wraps 2^N-1 -> 0, matching the decoder's write-address wrap.
- FSM states IDLE, WAIT, PLAY:
  - IDLE: if valid[rd_addr], go to WAIT next cycle. A write at edge N makes the head visible in IDLE in cycle N+1; WAIT is entered at edge N+1.
  - WAIT, with head start_time S, compared unsigned:
    - glb_counter == S: latch direction; latch len = max(pulse_len, 1); go to PLAY.
    - glb_counter > S: late_drop = 1 next cycle; retire the head; go to IDLE.
    - Otherwise stay in WAIT.
- PLAY:
  - pulse_active = 1 for exactly len cycles, starting the cycle after the match cycle; pulse_start = 1 in the first of those cycles.
  - Down-counter loaded with len on entry.
  - On its final active cycle, retire the head and go to IDLE.
  - Back-to-back pulses therefore have at least 2 idle cycles between them (IDLE, then WAIT).
- Outputs and timing:
  - All outputs are registered except list_empty = ~valid[rd_addr].
  - pulse_direction holds its last value after the pulse ends.
  - pulse_len changes during PLAY have no effect.
  - glb_counter wrap is not handled: after wrap, an unplayed entry looks future-dated and waits.
- Reset:
  - Clears all valid bits, rd_addr, FSM (-> IDLE), the down-counter, pulse_active, pulse_start, late_drop, overflow, and pulse_direction (0).
  - Reset mid-PLAY drops pulse_active in the cycle after the rst edge.
  - List data contents are don't-care after reset.

Test Plan:
- Reset, then write slot0 {S=100, dir=2}, pulse_len=4, glb_counter counting from 90 -> glb_counter==100 seen in cycle T; pulse_active=1 cycles T+1..T+4; pulse_start at T+1 only; pulse_direction=2; rd_addr=1; list_empty=1.
- Write slot0 {S=5} while glb_counter=50 -> late_drop single pulse, no pulse_active, rd_addr advances to 1.
- Write 32 entries (full wrap) with increasing S, then a 33rd write to slot0 before it plays -> overflow=1; slot0 plays the new data.
- Entries S=200 and S=203 with pulse_len=2 -> first pulse plays; second is dropped late (the 2-cycle gap is not met); late_drop asserted.
- pulse_len=0 -> pulse_active for exactly 1 cycle.
- Assert rst during PLAY cycle 2 of 5 -> pulse_active=0 the following cycle; rd_addr=0, list_empty=1, overflow=0.

Source files
------------

// File: rtl/pulse_inst_scheduler.sv
// Pulse instruction scheduler: holds the decoder's instruction list and plays one pulse per
// entry, in write order, when the global counter reaches the entry's start_time.
module pulse_inst_scheduler #(
    parameter int GLB_COUNTER_WIDTH    = 24,
    parameter int INST_LIST_ADDR_WIDTH = 5,
    parameter int DIRECTION_WIDTH      = 2,
    parameter int INST_LIST_DATA_WIDTH = GLB_COUNTER_WIDTH + DIRECTION_WIDTH,
    parameter int PULSE_LEN_WIDTH      = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            inst_list_wr_en,
    input  logic [INST_LIST_ADDR_WIDTH-1:0] inst_list_wr_addr,
    input  logic [INST_LIST_DATA_WIDTH-1:0] inst_list_wr_data,
    input  logic [GLB_COUNTER_WIDTH-1:0]    glb_counter,
    input  logic [PULSE_LEN_WIDTH-1:0]      pulse_len,
    output logic                            pulse_active,
    output logic [DIRECTION_WIDTH-1:0]      pulse_direction,
    output logic                            pulse_start,
    output logic                            late_drop,
    output logic                            overflow,
    output logic                            list_empty,
    output logic [INST_LIST_ADDR_WIDTH-1:0] rd_addr
);
    localparam int DEPTH = 1 << INST_LIST_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, PLAY} state_t;

    state_t                            state, state_next;
    logic [INST_LIST_DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]                  valid, valid_next;
    logic [PULSE_LEN_WIDTH-1:0]        cnt;
    logic [GLB_COUNTER_WIDTH-1:0]      head_time;
    logic [DIRECTION_WIDTH-1:0]        head_dir;
    logic                              head_valid;
    logic                              retire, match, late;

    assign {head_time, head_dir} = mem[rd_addr];
    assign head_valid            = valid[rd_addr];
    assign list_empty            = ~head_valid;

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        match      = 1'b0;
        late       = 1'b0;
        case (state)
            IDLE: if (head_valid) state_next = WAIT;
            WAIT: begin
                if (glb_counter == head_time) begin
                    match      = 1'b1;
                    state_next = PLAY;
                end else if (glb_counter > head_time) begin
                    late       = 1'b1;
                    retire     = 1'b1;
                    state_next = IDLE;
                end
            end
            PLAY: begin
                if (cnt == PULSE_LEN_WIDTH'(1)) begin
                    retire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A write to the head slot in its retire cycle wins over the clear.
    always_comb begin
        valid_next = valid;
        if (retire) valid_next[rd_addr] = 1'b0;
        if (inst_list_wr_en) valid_next[inst_list_wr_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (inst_list_wr_en) mem[inst_list_wr_addr] <= inst_list_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            valid           <= '0;
            rd_addr         <= '0;
            cnt             <= '0;
            pulse_active    <= 1'b0;
            pulse_start     <= 1'b0;
            late_drop       <= 1'b0;
            overflow        <= 1'b0;
            pulse_direction <= '0;
        end else begin
            state       <= state_next;
            valid       <= valid_next;
            pulse_start <= match;
            late_drop   <= late;
            if (match) begin
                pulse_active    <= 1'b1;
                pulse_direction <= head_dir;
                cnt             <= (pulse_len == '0) ? PULSE_LEN_WIDTH'(1) : pulse_len;
            end else if (state == PLAY) begin
                cnt <= cnt - PULSE_LEN_WIDTH'(1);
                if (retire) pulse_active <= 1'b0;
            end
            if (retire) rd_addr <= rd_addr + INST_LIST_ADDR_WIDTH'(1);
            if (inst_list_wr_en && valid[inst_list_wr_addr] &&
                !(retire && rd_addr == inst_list_wr_addr))
                overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pulse_inst_scheduler.sv
// Bench for pulse_inst_scheduler: a timeline model (absolute cycle windows) checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pulse_inst_scheduler;
    localparam int GW = 24, AW = 5, DW = 2, LW = 8, DEPTH = 32;

    logic          clk = 1'b0, rst = 1'b1, wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [GW+DW-1:0] wr_data = '0;
    logic [GW-1:0] glb = '0;
    logic [LW-1:0] plen = '0;
    logic          pulse_active, pulse_start, late_drop, overflow, list_empty;
    logic [DW-1:0] pulse_direction;
    logic [AW-1:0] rd_addr;

    always #5 clk = ~clk;

    pulse_inst_scheduler dut (
        .clk(clk), .rst(rst),
        .inst_list_wr_en(wr_en), .inst_list_wr_addr(wr_addr), .inst_list_wr_data(wr_data),
        .glb_counter(glb), .pulse_len(plen),
        .pulse_active(pulse_active), .pulse_direction(pulse_direction),
        .pulse_start(pulse_start), .late_drop(late_drop), .overflow(overflow),
        .list_empty(list_empty), .rd_addr(rd_addr)
    );

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: the scheduler is free (idle) at cycle free_at, may evaluate the head from
    // wait_from, and a matched pulse occupies the absolute window act_start..act_end.
    logic          m_valid [DEPTH];
    logic [GW-1:0] m_time  [DEPTH];
    logic [DW-1:0] m_dir   [DEPTH];
    int            m_rd = 0;
    longint        cyc = 0, free_at = 0, wait_from = -1, act_start = -1, act_end = -1;
    logic          e_active = 0, e_start = 0, e_late = 0, e_ovf = 0;
    logic [DW-1:0] e_dir = '0;
    bit            chk_en = 0;

    always @(posedge clk) begin
        longint cur;
        bit     ret;
        int     len;
        cur = cyc;
        cyc++;
        ret = 0;
        e_late = 0;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
            m_rd = 0; e_ovf = 0; e_dir = '0;
            free_at = cur + 1; wait_from = -1; act_start = -1; act_end = -1;
            chk_en = 1;
        end else begin
            if (cur >= act_start && cur <= act_end) begin
                if (cur == act_end) begin ret = 1; free_at = cur + 1; end
            end else if (wait_from >= 0 && cur >= wait_from) begin
                if (glb == m_time[m_rd]) begin
                    len = (plen == 0) ? 1 : int'(plen);
                    act_start = cur + 1; act_end = cur + len;
                    e_dir = m_dir[m_rd]; wait_from = -1;
                end else if (glb > m_time[m_rd]) begin
                    e_late = 1; ret = 1; free_at = cur + 1; wait_from = -1;
                end
            end else if (cur == free_at) begin
                if (m_valid[m_rd]) wait_from = cur + 1;
                else free_at = cur + 1;
            end
            if (ret) begin m_valid[m_rd] = 0; m_rd = (m_rd + 1) % DEPTH; end
            if (wr_en) begin
                if (m_valid[wr_addr]) e_ovf = 1;
                m_valid[wr_addr] = 1;
                {m_time[wr_addr], m_dir[wr_addr]} = wr_data;
            end
        end
        e_active = (cur + 1 >= act_start) && (cur + 1 <= act_end);
        e_start  = (cur + 1 == act_start);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pulse_active", pulse_active, e_active);
            chk("pulse_start", pulse_start, e_start);
            chk("late_drop", late_drop, e_late);
            chk("overflow", overflow, e_ovf);
            chk("pulse_direction", pulse_direction, e_dir);
            chk("rd_addr", rd_addr, m_rd);
            chk("list_empty", list_empty, !m_valid[m_rd]);
        end
    end

    int            n_act, n_start, n_late;
    logic [GW-1:0] first_act, last_act, first_start;
    logic [DW-1:0] first_dir;

    task automatic tick();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        glb = glb + 1'b1;
    endtask

    task automatic wr(input int a, input int s, input int d);
        wr_en = 1'b1;
        wr_addr = a[AW-1:0];
        wr_data = {s[GW-1:0], d[DW-1:0]};
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_act = 0; n_start = 0; n_late = 0;
        first_act = '0; last_act = '0; first_start = '0; first_dir = '0;
    endtask

    task automatic run_to(input int g);
        while (glb < g[GW-1:0]) begin
            tick();
            if (pulse_active) begin
                if (n_act == 0) first_act = glb;
                last_act = glb;
                n_act++;
            end
            if (pulse_start) begin
                if (n_start == 0) begin first_start = glb; first_dir = pulse_direction; end
                n_start++;
            end
            if (late_drop) n_late++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        // Reset state
        do_reset();
        chk("rst_active", pulse_active, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_empty", list_empty, 1);
        chk("rst_dir", pulse_direction, 0);

        // Basic pulse: S=100, dir=2, len=4
        glb = 90; plen = 4;
        wr(0, 100, 2);
        run_to(120);
        chk("t1_n_active", n_act, 4);
        chk("t1_first_active", first_act, 101);
        chk("t1_last_active", last_act, 104);
        chk("t1_n_start", n_start, 1);
        chk("t1_start_at", first_start, 101);
        chk("t1_dir", pulse_direction, 2);
        chk("t1_rd_addr", rd_addr, 1);
        chk("t1_empty", list_empty, 1);

        // Late entry
        do_reset();
        glb = 50;
        wr(0, 5, 1);
        run_to(60);
        chk("t2_n_late", n_late, 1);
        chk("t2_n_active", n_act, 0);
        chk("t2_rd_addr", rd_addr, 1);

        // Full wrap then overwrite of unconsumed slot0
        do_reset();
        glb = 0; plen = 3;
        for (int i = 0; i < DEPTH; i++) wr(i, 1000 + 10 * i, i % 4);
        wr(0, 500, 3);
        chk("t3_overflow", overflow, 1);
        run_to(1400);
        chk("t3_n_start", n_start, 32);
        chk("t3_n_late", n_late, 0);
        chk("t3_first_start", first_start, 501);
        chk("t3_first_dir", first_dir, 3);
        chk("t3_rd_addr", rd_addr, 0);
        chk("t3_overflow_sticky", overflow, 1);

        // Gap too short: second entry dropped
        do_reset();
        glb = 190; plen = 2;
        wr(0, 200, 0);
        wr(1, 203, 1);
        run_to(215);
        chk("t4_n_start", n_start, 1);
        chk("t4_n_active", n_act, 2);
        chk("t4_n_late", n_late, 1);
        chk("t4_rd_addr", rd_addr, 2);

        // Zero length plays one cycle
        do_reset();
        glb = 300; plen = 0;
        wr(0, 310, 1);
        run_to(320);
        chk("t5_n_active", n_act, 1);
        chk("t5_n_start", n_start, 1);

        // Reset during PLAY cycle 2 of 5
        do_reset();
        glb = 400; plen = 5;
        wr(0, 410, 2);
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            tick();
            if (pulse_active) seen = 1;
        end
        chk("t6_active_seen", seen, 1);
        plen = 9;
        tick();
        chk("t6_play_cycle2", pulse_active, 1);
        rst = 1'b1;
        tick();
        chk("t6_active_after_rst", pulse_active, 0);
        chk("t6_rd_addr", rd_addr, 0);
        chk("t6_empty", list_empty, 1);
        chk("t6_overflow", overflow, 0);
        rst = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
